// File: rtl/axi_mm_mem_arbiter.sv
// rtl/axi_mm_mem_arbiter.sv - two-master round-robin arbiter in front of one write/read memory port
//
// Purpose: shares a single memory instance (one write port, one read port with a
// 1-cycle registered read) between two masters. Write and read channels are
// arbitrated independently with their own round-robin pointers. All memory-side
// outputs are registered. Read data is routed back to the requester that issued
// the read, with a fixed 3-cycle grant-to-rvalid latency.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   mN_wreq / mN_wgnt              write request in, combinational write grant out
//   mN_waddr, mN_wdata, mN_wstrb   write word address, data, byte enables
//   mN_rreq / mN_rgnt              read request in, combinational read grant out
//   mN_raddr                       read word address
//   mN_rvalid, mN_rdata            one-cycle read response pulse, held read data
//   mem_wen, mem_waddr, mem_wdata, mem_wstrb   registered memory write port
//   mem_ren, mem_raddr             registered memory read port
//   mem_rdata                      memory read data, valid the cycle after mem_ren

module axi_mm_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_wreq,
  output logic                    m0_wgnt,
  input  logic [ADDR_BITS-1:0]    m0_waddr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m0_rreq,
  output logic                    m0_rgnt,
  input  logic [ADDR_BITS-1:0]    m0_raddr,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,

  input  logic                    m1_wreq,
  output logic                    m1_wgnt,
  input  logic [ADDR_BITS-1:0]    m1_waddr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_rreq,
  output logic                    m1_rgnt,
  input  logic [ADDR_BITS-1:0]    m1_raddr,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,

  output logic                    mem_wen,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [ADDR_BITS-1:0]    mem_waddr,
  output logic                    mem_ren,
  output logic [ADDR_BITS-1:0]    mem_raddr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // Round-robin pointers: id of the requester granted last on each channel.
  logic r_last_w;
  logic r_last_r;

  logic w_wgnt0;
  logic w_wgnt1;
  logic w_rgnt0;
  logic w_rgnt1;

  // Write side registers
  logic                  r_mem_wen;
  logic [STRB_W-1:0]     r_mem_wstrb;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [ADDR_BITS-1:0]  r_mem_waddr;

  // Read side: stage 1 sits alongside mem_ren, stage 2 alongside mem_rdata.
  logic                  r_mem_ren;
  logic [ADDR_BITS-1:0]  r_mem_raddr;
  logic                  r_tag_s1;
  logic                  r_vld_s2;
  logic                  r_tag_s2;
  logic                  r_m0_rvalid;
  logic                  r_m1_rvalid;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;

  // On contention the requester that did not win last time gets the grant;
  // r_last_* = 1 means requester 0 is favoured next.
  always_comb begin
    w_wgnt0 = rst_n & m0_wreq & (~m1_wreq | r_last_w);
    w_wgnt1 = rst_n & m1_wreq & (~m0_wreq | ~r_last_w);
    w_rgnt0 = rst_n & m0_rreq & (~m1_rreq | r_last_r);
    w_rgnt1 = rst_n & m1_rreq & (~m0_rreq | ~r_last_r);
  end

  assign m0_wgnt = w_wgnt0;
  assign m1_wgnt = w_wgnt1;
  assign m0_rgnt = w_rgnt0;
  assign m1_rgnt = w_rgnt1;

  // Write channel: register the winner's fields; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_w    <= 1'b1;
      r_mem_wen   <= 1'b0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
      r_mem_waddr <= '0;
    end else begin
      r_mem_wen <= w_wgnt0 | w_wgnt1;
      if (w_wgnt0) begin
        r_last_w    <= 1'b0;
        r_mem_wstrb <= m0_wstrb;
        r_mem_wdata <= m0_wdata;
        r_mem_waddr <= m0_waddr;
      end else if (w_wgnt1) begin
        r_last_w    <= 1'b1;
        r_mem_wstrb <= m1_wstrb;
        r_mem_wdata <= m1_wdata;
        r_mem_waddr <= m1_waddr;
      end
    end
  end

  // Read channel, stage 1: memory request plus the winner's id as a tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_r    <= 1'b1;
      r_mem_ren   <= 1'b0;
      r_mem_raddr <= '0;
      r_tag_s1    <= 1'b0;
    end else begin
      r_mem_ren <= w_rgnt0 | w_rgnt1;
      if (w_rgnt0) begin
        r_last_r    <= 1'b0;
        r_mem_raddr <= m0_raddr;
        r_tag_s1    <= 1'b0;
      end else if (w_rgnt1) begin
        r_last_r    <= 1'b1;
        r_mem_raddr <= m1_raddr;
        r_tag_s1    <= 1'b1;
      end
    end
  end

  // Read channel, stage 2 and response: the tag follows the memory's own read
  // register, then mem_rdata is steered into the tagged requester's register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_s2    <= 1'b0;
      r_tag_s2    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_vld_s2    <= r_mem_ren;
      r_tag_s2    <= r_tag_s1;
      r_m0_rvalid <= r_vld_s2 & ~r_tag_s2;
      r_m1_rvalid <= r_vld_s2 & r_tag_s2;
      if (r_vld_s2 && !r_tag_s2) begin
        r_m0_rdata <= mem_rdata;
      end
      if (r_vld_s2 && r_tag_s2) begin
        r_m1_rdata <= mem_rdata;
      end
    end
  end

  assign mem_wen   = r_mem_wen;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign mem_waddr = r_mem_waddr;
  assign mem_ren   = r_mem_ren;
  assign mem_raddr = r_mem_raddr;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_axi_mm_mem_arbiter.sv
// tb/tb_axi_mm_mem_arbiter.sv - self-checking bench for axi_mm_mem_arbiter
//
// Purpose: drives both masters, models a read-before-write memory behind the
// arbiter, and compares grants, memory-side registers and read responses with
// a reference arbiter/memory model and a scoreboard of expected reads.

module tb_axi_mm_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_wreq, m1_wreq, m0_rreq, m1_rreq;
  logic          m0_wgnt, m1_wgnt, m0_rgnt, m1_rgnt;
  logic [AW-1:0] m0_waddr, m1_waddr, m0_raddr, m1_raddr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_wen, mem_ren;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  axi_mm_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_wreq(m0_wreq), .m0_wgnt(m0_wgnt), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rreq(m0_rreq), .m0_rgnt(m0_rgnt), .m0_raddr(m0_raddr),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_wreq(m1_wreq), .m1_wgnt(m1_wgnt), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rreq(m1_rreq), .m1_rgnt(m1_rgnt), .m1_raddr(m1_raddr),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // Memory behind the arbiter: registered read, read-before-write, byte strobes.
  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram[mem_raddr];
    if (mem_wen) begin
      for (int b = 0; b < SW; b++) begin
        if (mem_wstrb[b]) ram[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    int          cyc;
    bit          id;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       sb[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_last_w, m_last_r;
  logic          exp_wen, exp_ren;
  logic [SW-1:0] exp_wstrb;
  logic [DW-1:0] exp_wdata;
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_rd0, exp_rd1;
  int            cyc = 0;

  task automatic mdl_reset();
    m_last_w  = 1'b1;
    m_last_r  = 1'b1;
    exp_wen   = 1'b0;
    exp_ren   = 1'b0;
    exp_wstrb = '0;
    exp_wdata = '0;
    exp_waddr = '0;
    exp_raddr = '0;
    exp_rd0   = '0;
    exp_rd1   = '0;
    sb.delete();
  endtask

  // One clock cycle: sample at the falling edge, advance the model for the
  // rising edge that ends this cycle, then return just after that edge.
  task automatic step();
    bit ew0, ew1, er0, er1, erv0, erv1;
    logic [AW-1:0] ra;
    rd_exp_t e;
    @(negedge clk);
    check("mem_wen",   mem_wen,   exp_wen);
    check("mem_waddr", mem_waddr, exp_waddr);
    check("mem_wdata", mem_wdata, exp_wdata);
    check("mem_wstrb", mem_wstrb, exp_wstrb);
    check("mem_ren",   mem_ren,   exp_ren);
    check("mem_raddr", mem_raddr, exp_raddr);

    erv0 = 1'b0;
    erv1 = 1'b0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      if (sb[0].id) begin erv1 = 1'b1; exp_rd1 = sb[0].data; end
      else          begin erv0 = 1'b1; exp_rd0 = sb[0].data; end
      void'(sb.pop_front());
    end
    check("m0_rvalid", m0_rvalid, erv0);
    check("m1_rvalid", m1_rvalid, erv1);
    check("m0_rdata",  m0_rdata,  exp_rd0);
    check("m1_rdata",  m1_rdata,  exp_rd1);

    ew0 = rst_n && m0_wreq && (!m1_wreq || m_last_w);
    ew1 = rst_n && m1_wreq && (!m0_wreq || !m_last_w);
    er0 = rst_n && m0_rreq && (!m1_rreq || m_last_r);
    er1 = rst_n && m1_rreq && (!m0_rreq || !m_last_r);
    check("m0_wgnt", m0_wgnt, ew0);
    check("m1_wgnt", m1_wgnt, ew1);
    check("m0_rgnt", m0_rgnt, er0);
    check("m1_rgnt", m1_rgnt, er1);

    if (!rst_n) begin
      mdl_reset();
    end else begin
      exp_ren = er0 | er1;
      if (er0 | er1) begin
        ra         = er0 ? m0_raddr : m1_raddr;
        exp_raddr  = ra;
        m_last_r   = er1;
        e.cyc      = cyc + 3;
        e.id       = er1;
        e.data     = ref_mem[ra];  // old contents: same-cycle write lands later
        sb.push_back(e);
      end
      exp_wen = ew0 | ew1;
      if (ew0 | ew1) begin
        exp_waddr = ew0 ? m0_waddr : m1_waddr;
        exp_wdata = ew0 ? m0_wdata : m1_wdata;
        exp_wstrb = ew0 ? m0_wstrb : m1_wstrb;
        m_last_w  = ew1;
        for (int b = 0; b < SW; b++) begin
          if (exp_wstrb[b]) ref_mem[exp_waddr][8*b +: 8] = exp_wdata[8*b +: 8];
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_wreq = 1'b0; m1_wreq = 1'b0; m0_rreq = 1'b0; m1_rreq = 1'b0;
  endtask

  task automatic w0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    m0_wreq = 1'b1; m0_waddr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic w1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    m1_wreq = 1'b1; m1_waddr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    mem_rdata = '0;
    mdl_reset();
    m0_waddr = '0; m1_waddr = '0; m0_raddr = '0; m1_raddr = '0;
    m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;

    // Reset with every request asserted
    rst_n = 1'b0;
    m0_wreq = 1'b1; m1_wreq = 1'b1; m0_rreq = 1'b1; m1_rreq = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();

    // Round-robin on writes: first grant after release goes to m0
    rst_n = 1'b1;
    m0_rreq = 1'b0; m1_rreq = 1'b0;
    w0(10'd10, 32'h0000_1010, 4'hF);
    w1(10'd11, 32'h0000_1111, 4'hF);
    repeat (6) step();
    idle();
    step();

    // Read routing: populate 5 and 6, then both masters read in one cycle
    w0(10'd5, 32'hA5A5_A5A5, 4'hF);
    w1(10'd6, 32'h1234_5678, 4'hF);
    step();
    m0_wreq = 1'b0;
    step();
    idle();
    m0_rreq = 1'b1; m0_raddr = 10'd5;
    m1_rreq = 1'b1; m1_raddr = 10'd6;
    step();
    m0_rreq = 1'b0;
    step();
    idle();
    repeat (5) step();

    // Byte strobe and same-cycle read/write hazard at address 3
    w0(10'd3, 32'hFFFF_FFFF, 4'hF);
    step();
    idle();
    w0(10'd3, 32'h0000_0000, 4'b0011);
    m1_rreq = 1'b1; m1_raddr = 10'd3;
    step();
    m0_wreq = 1'b0;
    step();
    idle();
    repeat (5) step();

    // Reset while a read is in flight: the response must be discarded
    m0_rreq = 1'b1; m0_raddr = 10'd5;
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();

    // Throughput: 8 writes then 8 back-to-back reads from m0, with m1 writing
    // concurrently during the reads
    for (int i = 0; i < 8; i++) begin
      w0(i[AW-1:0], 32'h0100_0000 + 32'h11 * i, 4'hF);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      m0_rreq = 1'b1; m0_raddr = i[AW-1:0];
      w1(10'd100 + i[AW-1:0], 32'hBEEF_0000 + i, 4'hF);
      step();
    end
    idle();
    repeat (5) step();

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
